// File: rtl/cpu_types_pkg.sv
// Shared execute-stage types: operand word, multiply/divide opcodes and FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} muldiv_op_t;

  typedef enum logic [2:0] {MD_IDLE, MD_PREP, MD_RUN, MD_FIX, MD_DONE} muldiv_state_t;

  localparam int MD_ITERS = 32;

  function automatic logic md_is_signed(muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-step shift-add multiplier / restoring divider writing HI/LO.
// 35 cycles start-to-done (2 for divide by zero); busy stalls the pipe, flush aborts.
module muldiv_unit
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       flush,
  input  muldiv_op_t op,
  input  word_t      rs,
  input  word_t      rt,
  output logic       busy,
  output logic       done,
  output logic       div_zero,
  output word_t      hi,
  output word_t      lo
);

  localparam int MSB = WIDTH - 1;
  localparam logic [4:0] LAST_ITER = 5'(MD_ITERS - 1);

  muldiv_state_t state_q;
  muldiv_op_t    op_q;
  word_t         rs_q, rt_q, opnd_q, rem_q, hi_q, lo_q;
  logic [63:0]   acc_q;
  logic [4:0]    cnt_q;
  logic          neg_res_q, neg_dvd_q, busy_q, done_q, dz_q;

  logic          is_div, is_signed, div_ge;
  word_t         rs_mag, rt_mag, div_diff, rem_d;
  logic [32:0]   mul_sum, div_shift;
  logic [63:0]   acc_d, result_d;

  // Product is sign-corrected as a whole; quotient and remainder take separate signs.
  function automatic logic [63:0] fix_signs(muldiv_op_t f_op, logic [63:0] f_acc, word_t f_rem,
                                            logic f_neg_res, logic f_neg_dvd);
    word_t q, r;
    if (md_is_div(f_op)) begin
      q = f_neg_res ? -f_acc[31:0] : f_acc[31:0];
      r = f_neg_dvd ? -f_rem : f_rem;
      return {r, q};
    end
    return f_neg_res ? -f_acc : f_acc;
  endfunction

  always_comb begin
    is_div    = md_is_div(op_q);
    is_signed = md_is_signed(op_q);
    rs_mag    = (is_signed && rs_q[MSB]) ? -rs_q : rs_q;
    rt_mag    = (is_signed && rt_q[MSB]) ? -rt_q : rt_q;

    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);

    // A set top bit of the shifted remainder already guarantees it exceeds any divisor.
    div_shift = {rem_q, acc_q[31]};
    div_ge    = div_shift[32] || (div_shift[31:0] >= opnd_q);
    div_diff  = div_shift[31:0] - opnd_q;

    if (is_div) begin
      acc_d = {acc_q[63:32], acc_q[30:0], div_ge};
      rem_d = div_ge ? div_diff : div_shift[31:0];
    end else begin
      acc_d = {mul_sum, acc_q[31:1]};
      rem_d = rem_q;
    end

    result_d = fix_signs(op_q, acc_q, rem_q, neg_res_q, neg_dvd_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= MD_IDLE;
      op_q      <= MD_MULT;
      rs_q      <= '0;
      rt_q      <= '0;
      opnd_q    <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_dvd_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else if (flush && state_q != MD_IDLE) begin
      state_q <= MD_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE, MD_DONE: begin
          done_q <= 1'b0;
          if (start && !flush) begin
            state_q <= MD_PREP;
            op_q    <= op;
            rs_q    <= rs;
            rt_q    <= rt;
            dz_q    <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= MD_IDLE;
          end
        end
        MD_PREP: begin
          if (is_div && rt_q == '0) begin
            dz_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= MD_DONE;
          end else begin
            neg_res_q <= is_signed && (rs_q[MSB] ^ rt_q[MSB]);
            neg_dvd_q <= is_signed && rs_q[MSB];
            opnd_q    <= is_div ? rt_mag : rs_mag;
            acc_q     <= {32'd0, is_div ? rs_mag : rt_mag};
            rem_q     <= '0;
            cnt_q     <= '0;
            state_q   <= MD_RUN;
          end
        end
        MD_RUN: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_ITER) state_q <= MD_FIX;
        end
        MD_FIX: begin
          hi_q    <= result_d[63:32];
          lo_q    <= result_d[31:0];
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= MD_DONE;
        end
        default: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic, timing, flush, reset.
module tb_muldiv_unit;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       RST, start, flush;
  muldiv_op_t op;
  word_t      rs, rt;
  logic       busy, done, div_zero;
  word_t      hi, lo;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .flush(flush), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    muldiv_op_t op;
    word_t      a;
    word_t      b;
    word_t      ehi;
    word_t      elo;
  } vec_t;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Called in cycle 0 (just after an edge); returns in cycle 1 with operands scrambled.
  task automatic issue(input muldiv_op_t o, input word_t a, input word_t b);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    tick();
    start = 1'b0;
    rs    = $urandom;
    rt    = $urandom;
  endtask

  task automatic wait_done(input int c0, output int lat);
    lat = c0;
    while (done !== 1'b1 && lat < 80) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; flush = 1'b0; op = MD_MULT; rs = '0; rt = '0;
    repeat (2) @(posedge CLK);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b want=0", div_zero); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_multu_timing();
    int errs;
    errs = 0;
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int c = 1; c <= 34; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) errs++;
      tick();
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL multu_busy_window bad_cycles=%0d want=0", errs); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL multu_done_c35 got=%b want=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL multu_busy_c35 got=%b want=0", busy); end
    total++; if (hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi got=%h want=fffffffe", hi); end
    total++; if (lo !== 32'h00000001) begin bad++; $display("FAIL multu_lo got=%h want=00000001", lo); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_arith();
    vec_t v [7];
    int   lat;
    v[0] = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    v[1] = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    v[2] = '{MD_MULT,  32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    v[3] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    v[4] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    v[5] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    v[6] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    for (int i = 0; i < 7; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_done(1, lat);
      total++; if (lat !== 35) begin bad++; $display("FAIL arith%0d_latency got=%0d want=35", i, lat); end
      total++; if (hi !== v[i].ehi) begin bad++; $display("FAIL arith%0d_hi got=%h want=%h", i, hi, v[i].ehi); end
      total++; if (lo !== v[i].elo) begin bad++; $display("FAIL arith%0d_lo got=%h want=%h", i, lo, v[i].elo); end
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL arith%0d_dz got=%b want=0", i, div_zero); end
      tick();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    issue(MD_DIVU, 32'h451, 32'h20);
    wait_done(1, lat);
    total++; if (hi !== 32'h11 || lo !== 32'h22) begin bad++; $display("FAIL dz_setup got=%h/%h want=11/22", hi, lo); end
    tick();
    issue(MD_DIVU, 32'd5, 32'd0);
    wait_done(1, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL dz_latency got=%0d want=2", lat); end
    total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b want=1", div_zero); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dz_busy got=%b want=0", busy); end
    total++; if (hi !== 32'h11) begin bad++; $display("FAIL dz_hi_kept got=%h want=11", hi); end
    total++; if (lo !== 32'h22) begin bad++; $display("FAIL dz_lo_kept got=%h want=22", lo); end
    tick();
    total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_sticky got=%b want=1", div_zero); end
    issue(MD_MULTU, 32'd2, 32'd3);
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL dz_clear got=%b want=0", div_zero); end
    wait_done(1, lat);
    total++; if (lo !== 32'd6 || hi !== 32'd0) begin bad++; $display("FAIL dz_next_op got=%h/%h want=0/6", hi, lo); end
    tick();
  endtask

  task automatic test_flush();
    int lat;
    issue(MD_MULT, 32'd5, 32'd6);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL flush_done got=%b want=0", done); end
    total++; if (hi !== 32'd0 || lo !== 32'd6) begin bad++; $display("FAIL flush_kept got=%h/%h want=0/6", hi, lo); end
    issue(MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(1, lat);
    total++; if (lat !== 35) begin bad++; $display("FAIL flush_restart_latency got=%0d want=35", lat); end
    total++; if (hi !== 32'd0 || lo !== 32'd1) begin bad++; $display("FAIL flush_restart_res got=%h/%h want=0/1", hi, lo); end
    tick();
    issue(MD_MULTU, 32'd9, 32'd9);
    repeat (33) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_fix_busy got=%b want=1", busy); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (lo !== 32'd1 || done !== 1'b0) begin bad++; $display("FAIL flush_fix_kept lo=%h done=%b want lo=1 done=0", lo, done); end
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flush_fix_idle done=%b busy=%b want 0/0", done, busy); end
    start = 1'b1; flush = 1'b1; op = MD_MULTU; rs = 32'd4; rt = 32'd4;
    tick();
    start = 1'b0; flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_start_drop got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_done(1, lat);
    total++; if (hi !== 32'd2 || lo !== 32'd14) begin bad++; $display("FAIL b2b_first got=%h/%h want=2/e", hi, lo); end
    issue(MD_MULTU, 32'd3, 32'd4);
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL b2b_accept busy=%b done=%b want 1/0", busy, done); end
    wait_done(1, lat);
    total++; if (lat !== 35) begin bad++; $display("FAIL b2b_latency got=%0d want=35", lat); end
    total++; if (hi !== 32'd0 || lo !== 32'd12) begin bad++; $display("FAIL b2b_second got=%h/%h want=0/c", hi, lo); end
    tick();
  endtask

  task automatic test_start_ignored();
    int lat;
    issue(MD_MULTU, 32'd7, 32'd8);
    repeat (4) tick();
    start = 1'b1; op = MD_DIVU; rs = 32'd1; rt = 32'd0;
    tick();
    start = 1'b0;
    wait_done(6, lat);
    total++; if (lat !== 35) begin bad++; $display("FAIL ign_latency got=%0d want=35", lat); end
    total++; if (hi !== 32'd0 || lo !== 32'd56) begin bad++; $display("FAIL ign_result got=%h/%h want=0/38", hi, lo); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL ign_dz got=%b want=0", div_zero); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_no_queue got=%b want=0", busy); end
  endtask

  task automatic test_rst_mid();
    int lat;
    issue(MD_DIV, 32'd1000, 32'd3);
    repeat (19) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy got=%b want=1", busy); end
    RST = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL rst_dz got=%b want=0", div_zero); end
    total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL rst_hilo got=%h/%h want=0/0", hi, lo); end
    #1;
    RST = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b want=0", busy); end
    issue(MD_DIV, 32'd1000, 32'd3);
    wait_done(1, lat);
    total++; if (hi !== 32'd1 || lo !== 32'd333) begin bad++; $display("FAIL rst_after_op got=%h/%h want=1/14d", hi, lo); end
    tick();
  endtask

  initial begin
    test_reset();
    test_multu_timing();
    test_arith();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_start_ignored();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit for the execute stage, alongside the single-cycle ALU. It takes MULT/MULTU/DIV/DIVU operands from the ID/EX latch on a start pulse and runs a 32-iteration shift-add or restoring-divide loop. It writes the HI/LO pair, which MFHI/MFLO read. The hazard unit stalls on `busy` and can abort an in-flight operation with `flush`.

## Interface
- `WIDTH`, default 32: operand width, equal to `word_t`. Only 32 is supported.
- `CLK`  in  1: clock, rising edge.
- `RST`  in  1: reset, asynchronous, active-high.
- `start`  in  1: begin an operation; sampled in IDLE or DONE only.
- `flush`  in  1: abort the current operation; pipeline squash.
- `op`  in  2: `muldiv_op_t`, one of `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`.
- `rs`  in  32: multiplicand / dividend.
- `rt`  in  32: multiplier / divisor.
- `busy`  out  1: high in PREP, RUN and FIX.
- `done`  out  1: one-cycle pulse in DONE.
- `div_zero`  out  1: registered; set by a divide with `rt`==0, cleared by the next accepted start.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.

## Operation
- Reset values: state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, iteration counter 0.
- FSM states: IDLE, PREP, RUN, FIX, DONE.
- IDLE/DONE → PREP on `start`&!`flush`. Latch `op`, `rs`, `rt`; clear `div_zero`. Otherwise DONE → IDLE.
- PREP: take magnitudes for signed ops; record the sign of the result and the sign of the dividend.
  - DIV/DIVU with `rt`==0: set `div_zero`, go to DONE. `hi`/`lo` stay unchanged.
  - Otherwise go to RUN with the counter at 0.
- RUN: one iteration per cycle for 32 cycles.
  - Multiply: 64-bit accumulator, shift-add, LSB first.
  - Divide: restoring division; 33-bit partial remainder, one quotient bit per cycle, MSB first.
  - Counter at 31 → FIX.
- FIX: apply signs and write `hi`/`lo`, then go to DONE.
  - Multiply: negate the 64-bit product if the signs differ; `hi`=upper 32 bits, `lo`=lower 32 bits.
  - Divide: `lo`=quotient, negated if the operand signs differ; `hi`=remainder, taking the sign of the dividend.
- Unsigned ops never negate.
- Magnitude wrap: |0x80000000| = 0x80000000, treated as unsigned 33-bit. DIV 0x80000000 / -1 gives `lo`=0x80000000, `hi`=0, with no flag.
- `flush` in any state other than IDLE → IDLE on the next edge. No `done`; `hi`/`lo` unchanged, even if FIX is in progress.
- `flush` and `start` in the same cycle: flush wins; the start is dropped.
- `start` while `busy` is ignored, with no queueing.
- Operands are latched in PREP, so `rs`/`rt` may change after the start cycle.

## Timing
- Start sampled at the end of cycle 0.
- PREP is cycle 1; RUN is cycles 2–33; FIX is cycle 34, with `hi`/`lo` updated at the end of cycle 34.
- `done`=1 and `busy`=0 in cycle 35. Total latency: 35 cycles from start to done.
- Divide by zero: PREP in cycle 1, DONE in cycle 2, `div_zero`=1 from cycle 2.
- Back-to-back: `start` in the DONE cycle (35) puts PREP in cycle 36.
- `RST` asserted mid-operation: all outputs take their reset values immediately (asynchronous); IDLE after deassertion.
- `hi`, `lo`, `busy`, `done` and `div_zero` are all driven from flops, with no combinational path from the inputs.

## Structure
- `cpu_types_pkg` gains:
  - `typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} muldiv_op_t;`
  - the state enum `muldiv_state_t`;
  - `localparam MD_ITERS = 32`.
- `word_t` is used for all 32-bit ports.
- No sub-module: the FSM, the 64-bit accumulator and the 5-bit counter live in `muldiv_unit`. The sign fix-up is a combinational function within the module.

## Test plan
- MULTU `rs`=0xFFFFFFFF, `rt`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` exactly in cycle 35, `busy` high in cycles 1–34.
- MULT `rs`=-3, `rt`=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; MULT `rs`=-1, `rt`=-1 → `hi`=0, `lo`=1.
- DIV `rs`=-7, `rt`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; DIVU `rs`=100, `rt`=7 → `lo`=14, `hi`=2.
- DIVU with `rt`=0 after a prior result (`hi`=0x11, `lo`=0x22) → `div_zero`=1 and `done` in cycle 2, `hi`/`lo` stay 0x11/0x22. DIV 0x80000000 / -1 → `lo`=0x80000000, `hi`=0.
- `flush` in cycle 10 of a MULT → IDLE in cycle 11, no `done`, `hi`/`lo` unchanged; a new start in cycle 11 completes normally in cycle 46. `start` in the DONE cycle is accepted back-to-back.
- `RST` pulsed in cycle 20 of a DIV → `busy`/`done`/`hi`/`lo`/`div_zero`=0 immediately; `start` pulses while `busy` are ignored.
